// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle control sequencer for a small load/store core.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB. It decodes
// the strobes from the current state, the latched opcode and the live inputs.
// It also counts retired instructions and stops in HALT on a halt or illegal
// opcode.
//   clk, rst                : clock, synchronous active-high reset
//   opcode                  : instruction register bits [31:26]
//   imem_ready, dmem_ready  : instruction word valid / data access complete
//   zero                    : ALU zero flag (beq resolution)
//   ir_write, pc_write      : instruction register load / PC update
//   pc_src, alu_op          : PC source select / ALU operation class
//   mem_read, mem_write     : data memory strobes
//   reg_write, reg_dst,
//   mem_to_reg              : register file write controls
//   state                   : current state encoding
//   retired                 : completed-instruction count (wraps)
//   halted, illegal         : sticky stop flags
module stage_sequencer #(
   parameter int unsigned PC_W    = 10,
   parameter int unsigned CNT_W   = 16,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             zero,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             illegal
);

   // The PC datapath lives outside this block; only reject a degenerate width.
   if (PC_W == 0) begin : g_pc_w_invalid
      $error("stage_sequencer: PC_W must be nonzero");
   end

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] op_q;
   logic       retire_c, halt_c, illegal_c;

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == HALT_OP);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Opcode latch, retire counter and sticky stop flags
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= 6'h00;
         retired <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         if (state_q == S_DECODE) op_q <= opcode;
         if (retire_c)  retired <= retired + CNT_W'(1);
         if (halt_c)    halted  <= 1'b1;
         if (illegal_c) illegal <= 1'b1;
      end
   end

   // Next-state logic; DECODE steers on the live opcode since op_q loads this cycle
   always_comb begin
      state_d   = state_q;
      retire_c  = 1'b0;
      halt_c    = 1'b0;
      illegal_c = 1'b0;
      case (state_q)
         S_FETCH: if (imem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == HALT_OP) begin
               state_d = S_HALT;
               halt_c  = 1'b1;
            end else if (!is_legal(opcode)) begin
               state_d   = S_HALT;
               halt_c    = 1'b1;
               illegal_c = 1'b1;
            end else if (opcode == OP_J) begin
               state_d  = S_FETCH;
               retire_c = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:  state_d = S_MEM;
               OP_BEQ: begin
                  state_d  = S_FETCH;
                  retire_c = 1'b1;
               end
               default:       state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d  = S_FETCH;
                  retire_c = 1'b1;
               end
            end
         end
         S_WB: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Output decode; every strobe is zero outside the state that owns it
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_op     = 2'd0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write = imem_ready;
            pc_write = imem_ready;
         end
         S_DECODE: begin
            if (opcode == OP_J && opcode != HALT_OP) begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R:   alu_op = 2'd2;
               OP_BEQ: begin
                  alu_op   = 2'd1;
                  pc_write = zero;
                  pc_src   = 2'd1;
               end
               default: alu_op = 2'd0;
            endcase
         end
         S_MEM: begin
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OP_R);
            mem_to_reg = (op_q == OP_LW);
         end
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer; a second narrow-counter instance covers wrap.
module tb_stage_sequencer;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   logic        clk = 1'b0;
   logic        rst, imem_ready, dmem_ready, zero;
   logic [5:0]  opcode;
   logic        ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
   logic [1:0]  pc_src, alu_op;
   logic [2:0]  state;
   logic [15:0] retired;
   logic        halted, illegal;

   logic        rst2;
   logic        ir_write2, pc_write2, mem_read2, mem_write2, reg_write2, reg_dst2, mem_to_reg2;
   logic [1:0]  pc_src2, alu_op2;
   logic [2:0]  state2;
   logic [3:0]  retired2;
   logic        halted2, illegal2;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   stage_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .zero(zero), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .state(state), .retired(retired), .halted(halted), .illegal(illegal)
   );

   stage_sequencer #(.CNT_W(4)) dut_wrap (
      .clk(clk), .rst(rst2), .opcode(OP_R), .imem_ready(1'b1),
      .dmem_ready(1'b1), .zero(1'b0), .ir_write(ir_write2), .pc_write(pc_write2),
      .pc_src(pc_src2), .alu_op(alu_op2), .mem_read(mem_read2), .mem_write(mem_write2),
      .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
      .state(state2), .retired(retired2), .halted(halted2), .illegal(illegal2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg}
   function automatic logic [6:0] strobes();
      return {ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg};
   endfunction

   logic [2:0] exp_state [9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
   logic [6:0] exp_strb  [9] = '{7'b1100000, 7'b0000000, 7'b0000000, 7'b0000110,
                                 7'b1100000, 7'b0000000, 7'b0000000, 7'b0010000,
                                 7'b0000101};

   initial begin
      rst = 1'b1; rst2 = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
      opcode = 6'h00;
      step(); step();
      rst = 1'b0;
      check("rst_state", 32'(state), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);

      // R-type then lw; junk opcode outside DECODE must not matter
      for (int i = 0; i < 9; i++) begin
         opcode = (i == 1) ? OP_R : (i == 5) ? OP_LW : 6'h11;
         #1;
         check($sformatf("rlw_state%0d", i), 32'(state), 32'(exp_state[i]));
         check($sformatf("rlw_strb%0d", i), 32'(strobes()), 32'(exp_strb[i]));
         if (i == 2) check("r_alu_op", 32'(alu_op), 32'd2);
         if (i == 6) check("lw_alu_op", 32'(alu_op), 32'd0);
         step();
      end
      check("rlw_retired", 32'(retired), 32'd2);

      // sw with three wait cycles in MEM
      opcode = OP_SW;
      step(); step();
      check("sw_exec", 32'(state), 32'd2);
      check("sw_alu_op", 32'(alu_op), 32'd0);
      step();
      for (int k = 0; k < 4; k++) begin
         dmem_ready = (k == 3);
         #1;
         check($sformatf("sw_mem_write%0d", k), 32'(mem_write), 32'd1);
         check($sformatf("sw_state%0d", k), 32'(state), 32'd3);
         check($sformatf("sw_retired_hold%0d", k), 32'(retired), 32'd2);
         step();
      end
      check("sw_fetch", 32'(state), 32'd0);
      check("sw_retired", 32'(retired), 32'd3);

      // beq not taken, then taken
      opcode = OP_BEQ;
      for (int t = 0; t < 2; t++) begin
         zero = (t == 1);
         step(); step();
         check($sformatf("beq_state%0d", t), 32'(state), 32'd2);
         check($sformatf("beq_alu_op%0d", t), 32'(alu_op), 32'd1);
         check($sformatf("beq_pc_write%0d", t), 32'(pc_write), 32'(t));
         check($sformatf("beq_pc_src%0d", t), 32'(pc_src), 32'd1);
         step();
         check($sformatf("beq_fetch%0d", t), 32'(state), 32'd0);
         check($sformatf("beq_retired%0d", t), 32'(retired), 32'(4 + t));
      end

      // jump: two cycles
      opcode = OP_J;
      step();
      check("j_pc_write", 32'(pc_write), 32'd1);
      check("j_pc_src", 32'(pc_src), 32'd2);
      step();
      check("j_fetch", 32'(state), 32'd0);
      check("j_retired", 32'(retired), 32'd6);

      // reset while lw waits in MEM
      opcode = OP_LW; dmem_ready = 1'b0;
      step(); step(); step();
      check("lw_wait_state", 32'(state), 32'd3);
      check("lw_wait_mem_read", 32'(mem_read), 32'd1);
      rst = 1'b1;
      step();
      check("mrst_state", 32'(state), 32'd0);
      check("mrst_mem_read", 32'(mem_read), 32'd0);
      check("mrst_retired", 32'(retired), 32'd0);
      rst = 1'b0; dmem_ready = 1'b1;

      // halt opcode: terminal, no strobes
      opcode = 6'h3F;
      step(); step();
      check("halt_state", 32'(state), 32'd5);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_illegal", 32'(illegal), 32'd0);
      for (int k = 0; k < 20; k++) begin
         opcode = 6'(k);
         zero = k[0];
         #1;
         check($sformatf("halt_quiet%0d", k), 32'({strobes(), pc_src, alu_op, state}), 32'd5);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("halt_rst_state", 32'(state), 32'd0);
      check("halt_rst_halted", 32'(halted), 32'd0);

      // illegal opcode
      opcode = 6'h11;
      step(); step();
      check("ill_state", 32'(state), 32'd5);
      check("ill_illegal", 32'(illegal), 32'd1);
      check("ill_halted", 32'(halted), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("ill_rst_illegal", 32'(illegal), 32'd0);

      // retired wraps on a 4-bit counter: 15 R-types then one more
      rst2 = 1'b0;
      for (int c = 0; c < 60; c++) step();
      check("wrap_pre", 32'(retired2), 32'd15);
      for (int c = 0; c < 4; c++) step();
      check("wrap_zero", 32'(retired2), 32'd0);
      check("wrap_no_flag", 32'({halted2, illegal2}), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
